latch_wr_seq: RTL and testbench
===============================

# latch_wr_seq

Write sequencer that drives a bank of N transparent latches (W bits each) through their enable/data interface, the writer side of latch-based register storage. It accepts write requests on a valid/ready handshake, buffers up to two of them, and replays each as a glitch-free setup / enable-pulse / hold sequence, all outputs registered. It sits between the core's write-back logic and any latch-based storage array, such as the register file or CSR shadow latches.

## Interface
- W, 32, data width of each target latch
- N, 32, number of target latches (enable lines)
- AW, 5, request address width; N <= 2**AW
- clk  in  1  system clock, rising edge
- a_reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write request present
- req_ready  out  1  sequencer can accept a request
- req_addr  in  AW  target latch index
- req_data  in  W  value to write
- lat_en  out  N  one-hot latch enables, at most one bit high, driven straight from a flop
- lat_data  out  W  data bus to all latches, driven straight from a flop
- wr_done  out  1  one-cycle pulse, high in the HOLD cycle of each completed write
- wr_err  out  1  one-cycle pulse, high the cycle after an out-of-range request is accepted
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty

## Operation
- Handshake: a request is accepted at a rising edge when req_valid && req_ready. req_ready = !fifo_full and depends only on registered state, never on req_valid.
- Range check at acceptance: if req_addr >= N, the request is consumed but not enqueued, and wr_err pulses in the next cycle. In-range requests are pushed into a 2-entry FIFO holding {addr, data}, kept in arrival order.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE: lat_en = 0 and lat_data holds its last value. If the FIFO is non-empty, pop the head into addr_q and lat_data, then go to SETUP.
  - SETUP: lat_en = 0 and lat_data is stable. Go to PULSE unconditionally.
  - PULSE: lat_en = 1 << addr_q for exactly one cycle, with lat_data unchanged. Go to HOLD.
  - HOLD: lat_en = 0, lat_data unchanged, wr_done = 1. If the FIFO is non-empty, pop the head and go to SETUP; otherwise go to IDLE.
- lat_data changes only on the edge entering SETUP. It never changes in the same cycle as, or the cycle after, a lat_en high cycle.
- Push and pop at the same edge: both take effect, so occupancy is unchanged. A pop from a full FIFO does not raise req_ready in that same cycle.
- A request arriving while the FIFO is empty is not bypassed. It always passes through the FIFO and IDLE.

## Timing
- Reset (asynchronous, takes effect immediately): lat_en = 0, lat_data = 0, wr_done = 0, wr_err = 0, FIFO empty, state IDLE. Once reset is released and the FIFO is empty, busy = 0 and req_ready = 1.
- Reset asserted mid-sequence, including during PULSE: lat_en drops to 0 without waiting for a clock edge. Pending FIFO entries are discarded and no wr_done is issued for them.
- Latency, with the request accepted at edge k:
  - SETUP during cycle k+1 (entered at edge k+1)
  - PULSE during cycle k+2
  - HOLD and wr_done during cycle k+3
  - IDLE at k+4
- Throughput: back-to-back writes complete every 3 cycles (HOLD goes directly to SETUP). A continuous stream keeps the FIFO near full, and req_ready toggles accordingly.
- wr_err has a latency of 1 cycle and does not occupy the FSM or the FIFO.

## Test plan
- Reset, then a single write of addr=5, data=0xDEADBEEF accepted at edge k: lat_data = 0xDEADBEEF from k+1, lat_en = 0x00000020 only in cycle k+2, wr_done in cycle k+3, busy = 0 from k+4, and lat_data still reads 0xDEADBEEF in IDLE.
- Three requests with req_valid held high (addr 0, 1, 31 with data 1, 2, 3): req_ready deasserts when the FIFO is full. The lat_en one-hot values 0x1, 0x2 and 0x80000000 appear exactly 3 cycles apart, in order, each with its matching data. No lat_data change occurs in any PULSE or HOLD cycle.
- Request with addr=32 while N=32: accepted, wr_err pulses for one cycle, lat_en stays 0, busy is unaffected, and the FIFO is not written.
- Assert a_reset_n low in the middle of the PULSE cycle with a second request queued: lat_en goes to 0 immediately and lat_data goes to 0. After release, neither wr_done nor lat_en ever appears for the queued request.
- Random traffic for 10k cycles, checking against a reference model:
  - every in-range request produces exactly one lat_en pulse with the correct index and data, in order
  - $onehot0(lat_en) holds every cycle
  - req_ready == !full holds every cycle
- Parameter sweep with N=4, AW=2, W=8: addr 3 writes correctly, and the upper lat_en bits do not exist.

Source files
------------

// File: rtl/latch_wr_seq_if.sv
// Request and latch-side bus of the latch write sequencer.
// The master drives requests; the slave (sequencer) drives the latch bank.
interface latch_wr_seq_if #(
  parameter int W  = 32,
  parameter int N  = 32,
  parameter int AW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data;
  logic [N-1:0]  lat_en;
  logic [W-1:0]  lat_data;
  logic          wr_done;
  logic          wr_err;
  logic          busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, lat_en, lat_data, wr_done, wr_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, lat_en, lat_data, wr_done, wr_err, busy
  );
endinterface

// File: rtl/latch_wr_seq.sv
// Write sequencer for a bank of transparent latches: 2-entry request FIFO feeding a
// setup / enable-pulse / hold sequence with every latch-side output taken from a flop.
//
// state | meaning
// IDLE  | no write in flight, lat_en low, lat_data holds last value
// SETUP | lat_data newly loaded and settling, lat_en low
// PULSE | one-hot enable high for exactly one cycle
// HOLD  | enable low, data held, wr_done pulses
module latch_wr_seq #(
  parameter int W  = 32,
  parameter int N  = 32,
  parameter int AW = 5
) (
  input logic           clk,
  input logic           a_reset_n,
  latch_wr_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  lat_en_q;
  logic [W-1:0]  lat_data_q;
  logic          wr_done_q;
  logic          wr_err_q;

  logic [AW-1:0] fifo_addr [2];
  logic [W-1:0]  fifo_data [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic          full;
  logic          empty;
  logic          in_range;
  logic          accept;
  logic          push;
  logic          pop;
  logic [N-1:0]  one_hot;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign in_range = (int'(bus.req_addr) < N);
  assign accept   = bus.req_valid && !full;
  assign push     = accept && in_range;
  assign pop      = ((state == IDLE) || (state == HOLD)) && !empty;
  assign one_hot  = {{(N-1){1'b0}}, 1'b1} << addr_q;

  // Storage needs no reset; occupancy and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.req_addr;
      fifo_data[wr_ptr] <= bus.req_data;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      lat_en_q   <= '0;
      lat_data_q <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_done_q <= (state == PULSE);
      wr_err_q  <= accept && !in_range;
      // Enable is loaded on the SETUP->PULSE edge so it rises a full cycle after the data.
      lat_en_q  <= (state == SETUP) ? one_hot : '0;
      case (state)
        IDLE, HOLD: begin
          if (pop) begin
            addr_q     <= fifo_addr[rd_ptr];
            lat_data_q <= fifo_data[rd_ptr];
            state      <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP:   state <= PULSE;
        PULSE:   state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = !full;
  assign bus.lat_en    = lat_en_q;
  assign bus.lat_data  = lat_data_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_latch_wr_seq.sv
// Bench for latch_wr_seq: directed scenarios plus random traffic checked against
// a schedule model (each write starts at max(accept+1, previous start+3)).
module tb_latch_wr_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  latch_wr_seq_if #(.W(32), .N(32), .AW(6)) bif ();
  latch_wr_seq_if #(.W(8),  .N(4),  .AW(2)) sif ();

  latch_wr_seq #(.W(32), .N(32), .AW(6)) dut (.clk(clk), .a_reset_n(rst_n), .bus(bif));
  latch_wr_seq #(.W(8),  .N(4),  .AW(2)) dut_small (.clk(clk), .a_reset_n(rst_n), .bus(sif));

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          s;
  } ent_t;

  task automatic idle_inputs();
    bif.req_valid = 1'b0;
    bif.req_addr  = '0;
    bif.req_data  = '0;
    sif.req_valid = 1'b0;
    sif.req_addr  = '0;
    sif.req_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tests++; if (bif.lat_en !== 32'h0) begin fails++; $display("FAIL reset_lat_en got=%h exp=0", bif.lat_en); end
    tests++; if (bif.lat_data !== 32'h0) begin fails++; $display("FAIL reset_lat_data got=%h exp=0", bif.lat_data); end
    tests++; if (bif.wr_done !== 1'b0 || bif.wr_err !== 1'b0) begin fails++; $display("FAIL reset_pulses done=%b err=%b exp=0,0", bif.wr_done, bif.wr_err); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
    tests++; if (bif.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bif.req_ready); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_addr = 6'd5; bif.req_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    tests++; if (bif.lat_en !== 32'h0 || bif.busy !== 1'b1) begin fails++; $display("FAIL single_k en=%h busy=%b exp=0,1", bif.lat_en, bif.busy); end
    @(negedge clk) bif.req_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (bif.lat_data !== 32'hDEADBEEF || bif.lat_en !== 32'h0) begin fails++; $display("FAIL single_setup data=%h en=%h exp=deadbeef,0", bif.lat_data, bif.lat_en); end
    @(posedge clk); #1;
    tests++; if (bif.lat_en !== 32'h20 || bif.lat_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_pulse en=%h data=%h exp=20,deadbeef", bif.lat_en, bif.lat_data); end
    @(posedge clk); #1;
    tests++; if (bif.lat_en !== 32'h0 || bif.wr_done !== 1'b1) begin fails++; $display("FAIL single_hold en=%h done=%b exp=0,1", bif.lat_en, bif.wr_done); end
    @(posedge clk); #1;
    tests++; if (bif.busy !== 1'b0 || bif.wr_done !== 1'b0 || bif.lat_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_idle busy=%b done=%b data=%h exp=0,0,deadbeef", bif.busy, bif.wr_done, bif.lat_data);
    end
  endtask

  task automatic test_back_to_back();
    int          addrs [3];
    logic [31:0] datas [3];
    int          pcyc [3];
    logic [31:0] pen [3];
    logic [31:0] pdat [3];
    int          idx, np, bad_stable;
    logic        rdy, saw_full;
    logic [31:0] prev_en, prev_data;
    addrs = '{0, 1, 31};
    datas = '{32'd1, 32'd2, 32'd3};
    idx = 0; np = 0; bad_stable = 0; saw_full = 1'b0;
    prev_en = bif.lat_en; prev_data = bif.lat_data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy = bif.req_ready;
      if (idx < 3) begin
        bif.req_valid = 1'b1; bif.req_addr = 6'(addrs[idx]); bif.req_data = datas[idx];
      end else bif.req_valid = 1'b0;
      @(posedge clk); #1;
      if (idx < 3 && rdy) idx++;
      if (!bif.req_ready) saw_full = 1'b1;
      if (bif.lat_en != 0) begin
        if (np < 3) begin pcyc[np] = c; pen[np] = bif.lat_en; pdat[np] = bif.lat_data; end
        np++;
      end
      if ((bif.lat_en != 0 || prev_en != 0) && bif.lat_data !== prev_data) bad_stable++;
      prev_en = bif.lat_en; prev_data = bif.lat_data;
    end
    tests++; if (np != 3) begin fails++; $display("FAIL b2b_pulse_count got=%0d exp=3", np); end
    tests++; if (!saw_full) begin fails++; $display("FAIL b2b_ready_deassert got=never exp=seen"); end
    tests++; if (bad_stable != 0) begin fails++; $display("FAIL b2b_data_stable changes=%0d exp=0", bad_stable); end
    if (np == 3) begin
      tests++; if (pen[0] !== 32'h1 || pen[1] !== 32'h2 || pen[2] !== 32'h80000000) begin
        fails++; $display("FAIL b2b_en_order got=%h,%h,%h exp=1,2,80000000", pen[0], pen[1], pen[2]);
      end
      tests++; if (pdat[0] !== 32'd1 || pdat[1] !== 32'd2 || pdat[2] !== 32'd3) begin
        fails++; $display("FAIL b2b_data got=%0d,%0d,%0d exp=1,2,3", pdat[0], pdat[1], pdat[2]);
      end
      tests++; if (pcyc[0] != 2 || pcyc[1] != 5 || pcyc[2] != 8) begin
        fails++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=2,5,8", pcyc[0], pcyc[1], pcyc[2]);
      end
    end
  endtask

  task automatic test_range_err();
    int bad;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_addr = 6'd32; bif.req_data = $urandom;
    @(posedge clk); #1;
    tests++; if (bif.wr_err !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", bif.wr_err); end
    tests++; if (bif.busy !== 1'b0 || bif.req_ready !== 1'b1) begin fails++; $display("FAIL err_no_enqueue busy=%b ready=%b exp=0,1", bif.busy, bif.req_ready); end
    @(negedge clk) bif.req_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (bif.wr_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got=%b exp=0", bif.wr_err); end
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bif.lat_en != 0 || bif.busy || bif.wr_done) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL err_no_write activity=%0d exp=0", bad); end
  endtask

  task automatic test_reset_in_pulse();
    int   bad, waited;
    logic found;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_addr = 6'd7; bif.req_data = 32'hA5A5_0007;
    @(posedge clk);
    @(negedge clk);
    bif.req_addr = 6'd9; bif.req_data = 32'h5A5A_0009;
    @(posedge clk);
    @(negedge clk) bif.req_valid = 1'b0;
    found = 1'b0; waited = 0;
    while (!found && waited < 10) begin
      @(posedge clk); #1;
      waited++;
      if (bif.lat_en != 0) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL rst_pulse_wait got=timeout exp=pulse"); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bif.lat_en !== 32'h0 || bif.lat_data !== 32'h0) begin fails++; $display("FAIL rst_async en=%h data=%h exp=0,0", bif.lat_en, bif.lat_data); end
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bif.lat_en != 0 || bif.wr_done || bif.busy) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rst_discard activity=%0d exp=0", bad); end
  endtask

  task automatic test_small_params();
    logic [3:0] en_seen;
    logic [7:0] data_seen;
    int         np, done_cnt;
    np = 0; done_cnt = 0; en_seen = '0; data_seen = '0;
    @(negedge clk);
    sif.req_valid = 1'b1; sif.req_addr = 2'd3; sif.req_data = 8'hA5;
    @(posedge clk);
    @(negedge clk) sif.req_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sif.lat_en != 0) begin np++; en_seen = sif.lat_en; data_seen = sif.lat_data; end
      if (sif.wr_done) done_cnt++;
    end
    tests++; if (np != 1 || en_seen !== 4'b1000) begin fails++; $display("FAIL small_en pulses=%0d en=%b exp=1,1000", np, en_seen); end
    tests++; if (data_seen !== 8'hA5 || done_cnt != 1) begin fails++; $display("FAIL small_data data=%h done=%0d exp=a5,1", data_seen, done_cnt); end
  endtask

  task automatic test_random_traffic();
    ent_t        q [$];
    ent_t        ent;
    int          last_s, occ, a, nwr;
    logic        v, rdy, acc, exp_done, exp_err;
    logic [31:0] d, exp_en, exp_data;
    do_reset();
    last_s = -100; exp_data = 32'h0; nwr = 0;
    for (int e = 1; e <= 10000; e++) begin
      @(negedge clk);
      v = ($urandom_range(0, 2) != 0);
      a = $urandom_range(0, 35);
      d = $urandom;
      bif.req_valid = v; bif.req_addr = 6'(a); bif.req_data = d;
      rdy = bif.req_ready;
      acc = v && rdy;
      @(posedge clk); #1;
      if (acc && a < 32) begin
        ent.addr = a; ent.data = d;
        ent.s = (e + 1 > last_s + 3) ? e + 1 : last_s + 3;
        last_s = ent.s;
        q.push_back(ent);
      end
      while (q.size() > 0 && q[0].s + 2 < e) void'(q.pop_front());
      exp_en = 32'h0; exp_done = 1'b0; occ = 0;
      foreach (q[i]) begin
        if (q[i].s == e) exp_data = q[i].data;
        if (q[i].s + 1 == e) begin exp_en = 32'h1 << q[i].addr; nwr++; end
        if (q[i].s + 2 == e) exp_done = 1'b1;
        if (q[i].s > e) occ++;
      end
      exp_err = acc && (a >= 32);
      tests++; if (bif.lat_en !== exp_en) begin fails++; $display("FAIL rnd_lat_en cyc=%0d got=%h exp=%h", e, bif.lat_en, exp_en); end
      tests++; if (bif.lat_data !== exp_data) begin fails++; $display("FAIL rnd_lat_data cyc=%0d got=%h exp=%h", e, bif.lat_data, exp_data); end
      tests++; if (bif.wr_done !== exp_done || bif.wr_err !== exp_err) begin
        fails++; $display("FAIL rnd_pulses cyc=%0d done=%b err=%b exp=%b,%b", e, bif.wr_done, bif.wr_err, exp_done, exp_err);
      end
      tests++; if (bif.req_ready !== (occ < 2)) begin fails++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", e, bif.req_ready, occ < 2); end
      tests++; if (bif.busy !== (q.size() != 0)) begin fails++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", e, bif.busy, q.size() != 0); end
      tests++; if (!$onehot0(bif.lat_en)) begin fails++; $display("FAIL rnd_onehot0 cyc=%0d got=%h exp=onehot0", e, bif.lat_en); end
      if (fails > 200) break;
    end
    bif.req_valid = 1'b0;
    tests++; if (nwr < 100) begin fails++; $display("FAIL rnd_traffic writes=%0d exp>=100", nwr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_range_err();
    test_reset_in_pulse();
    test_small_params();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
